// File: rtl/miriscv_lsu.sv
// rtl/miriscv_lsu.sv - load/store unit bridging core memory requests to a gnt/rvalid data bus
// Three-state FSM: IDLE issues directly from core inputs, REQ replays latched request, RESP extracts load data.

module miriscv_lsu (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_misalign_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i
);

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic        we_q;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  logic        legal;
  logic        issue;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;

  always_comb begin
    legal = 1'b0;
    case (lsu_size_i)
      SZ_B:  legal = 1'b1;
      SZ_H:  legal = ~lsu_addr_i[0];
      SZ_W:  legal = (lsu_addr_i[1:0] == 2'b00);
      SZ_BU: legal = ~lsu_we_i;
      SZ_HU: legal = ~lsu_we_i & ~lsu_addr_i[0];
      default: legal = 1'b0;
    endcase
  end

  // Loads use the same lane enables as an equal-size store
  always_comb begin
    be_in    = 4'b1111;
    wdata_in = lsu_data_i;
    case (lsu_size_i[1:0])
      2'b00: begin
        be_in    = 4'b0001 << lsu_addr_i[1:0];
        wdata_in = {4{lsu_data_i[7:0]}};
      end
      2'b01: begin
        be_in    = 4'b0011 << {lsu_addr_i[1], 1'b0};
        wdata_in = {2{lsu_data_i[15:0]}};
      end
      default: begin
        be_in    = 4'b1111;
        wdata_in = lsu_data_i;
      end
    endcase
  end

  always_comb begin
    rd_byte = data_rdata_i[7:0];
    case (off_q)
      2'd0: rd_byte = data_rdata_i[7:0];
      2'd1: rd_byte = data_rdata_i[15:8];
      2'd2: rd_byte = data_rdata_i[23:16];
      2'd3: rd_byte = data_rdata_i[31:24];
      default: rd_byte = data_rdata_i[7:0];
    endcase
    rd_half = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (size_q)
      SZ_B:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      SZ_BU: load_ext = {24'd0, rd_byte};
      SZ_H:  load_ext = {{16{rd_half[15]}}, rd_half};
      SZ_HU: load_ext = {16'd0, rd_half};
      SZ_W:  load_ext = data_rdata_i;
      default: load_ext = 32'd0;
    endcase
  end

  assign issue = (state_q == ST_IDLE) && lsu_req_i && legal;

  // Outputs are gated by arstn_i so everything reads zero while reset is held
  always_comb begin
    state_d         = state_q;
    data_req_o      = 1'b0;
    data_we_o       = 1'b0;
    data_be_o       = 4'b0000;
    data_addr_o     = 32'd0;
    data_wdata_o    = 32'd0;
    lsu_stall_req_o = 1'b0;
    lsu_misalign_o  = 1'b0;
    lsu_data_o      = 32'd0;
    if (arstn_i) begin
      case (state_q)
        ST_IDLE: begin
          if (lsu_req_i) begin
            if (legal) begin
              data_req_o      = 1'b1;
              data_we_o       = lsu_we_i;
              data_be_o       = be_in;
              data_addr_o     = {lsu_addr_i[31:2], 2'b00};
              data_wdata_o    = wdata_in;
              lsu_stall_req_o = 1'b1;
              state_d         = data_gnt_i ? ST_RESP : ST_REQ;
            end else begin
              lsu_misalign_o = 1'b1;
            end
          end
        end
        ST_REQ: begin
          data_req_o      = 1'b1;
          data_we_o       = we_q;
          data_be_o       = be_q;
          data_addr_o     = addr_q;
          data_wdata_o    = wdata_q;
          lsu_stall_req_o = 1'b1;
          if (data_gnt_i) state_d = ST_RESP;
        end
        ST_RESP: begin
          lsu_stall_req_o = ~data_rvalid_i;
          if (data_rvalid_i) begin
            state_d = ST_IDLE;
            if (!we_q) lsu_data_o = load_ext;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        we_q    <= lsu_we_i;
        size_q  <= lsu_size_i;
        off_q   <= lsu_addr_i[1:0];
        addr_q  <= {lsu_addr_i[31:2], 2'b00};
        be_q    <= be_in;
        wdata_q <= wdata_in;
      end
    end
  end

endmodule

// File: tb/tb_miriscv_lsu.sv
// tb/tb_miriscv_lsu.sv - self-checking bench for miriscv_lsu
// Scenario tasks drive the core and bus sides; expected load results travel through a queue.

module tb_miriscv_lsu;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        lsu_req_i, lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_data_i;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o, lsu_misalign_o;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic        data_gnt_i, data_rvalid_i;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  miriscv_lsu dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i), .lsu_data_o(lsu_data_o),
    .lsu_stall_req_o(lsu_stall_req_o), .lsu_misalign_o(lsu_misalign_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i)
  );

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    lsu_req_i = 0; lsu_we_i = 0; lsu_size_i = 0; lsu_addr_i = 0; lsu_data_i = 0;
    data_rdata_i = 0; data_gnt_i = 0; data_rvalid_i = 0;
  endtask

  // One full transaction; gnt arrives gnt_dly cycles after issue, rvalid the cycle after gnt
  task automatic do_access(input string name, input logic we, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata, input int gnt_dly,
                           input logic [31:0] rdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_load);
    logic [31:0] exp_d;
    lsu_req_i = 1; lsu_we_i = we; lsu_size_i = size; lsu_addr_i = addr; lsu_data_i = wdata;
    data_gnt_i = (gnt_dly == 0); data_rvalid_i = 0;
    exp_q.push_back(we ? 32'd0 : exp_load);
    for (int k = 0; k <= gnt_dly; k++) begin
      @(negedge clk_i);
      n_cmp++;
      if ({data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, lsu_stall_req_o, lsu_misalign_o} !==
          {1'b1, we, exp_be, {addr[31:2], 2'b00}, exp_wdata, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL %s req cycle %0d: req=%b we=%b be=%b addr=%h wdata=%h stall=%b mis=%b, want req=1 we=%b be=%b addr=%h wdata=%h stall=1 mis=0",
                 name, k, data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, lsu_stall_req_o,
                 lsu_misalign_o, we, exp_be, {addr[31:2], 2'b00}, exp_wdata);
      end
      next_cycle();
      if (k + 1 == gnt_dly) data_gnt_i = 1;
    end
    data_gnt_i = 0; lsu_req_i = 0; lsu_addr_i = 32'hFFFF_FFFF; lsu_size_i = 3'd2; lsu_we_i = ~we;
    data_rvalid_i = 1; data_rdata_i = rdata;
    @(negedge clk_i);
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
    n_cmp++;
    if ({data_req_o, lsu_stall_req_o, lsu_data_o} !== {1'b0, 1'b0, exp_d}) begin
      n_err++;
      $display("FAIL %s resp: req=%b stall=%b data=%h, want req=0 stall=0 data=%h",
               name, data_req_o, lsu_stall_req_o, lsu_data_o, exp_d);
    end
    next_cycle();
    data_rvalid_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    arstn_i = 0;
    lsu_req_i = 1; lsu_size_i = 3'd2; lsu_addr_i = 32'h100;
    #3;
    n_cmp++;
    if ({data_req_o, data_we_o, data_be_o, lsu_stall_req_o, lsu_misalign_o, lsu_data_o} !== 39'd0) begin
      n_err++;
      $display("FAIL reset_outputs: req=%b we=%b be=%b stall=%b mis=%b data=%h, want all 0",
               data_req_o, data_we_o, data_be_o, lsu_stall_req_o, lsu_misalign_o, lsu_data_o);
    end
    idle_inputs();
    next_cycle();
    next_cycle();
    arstn_i = 1;
  endtask

  task automatic test_loads();
    do_access("lw_0x100", 0, 3'd2, 32'h100, 0, 0, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'hDEAD_BEEF);
    do_access("lb_0x103", 0, 3'd0, 32'h103, 0, 0, 32'h80FF_FF7F, 4'b1000, 32'h0, 32'hFFFF_FF80);
    do_access("lbu_0x103", 0, 3'd4, 32'h103, 0, 0, 32'h80FF_FF7F, 4'b1000, 32'h0, 32'h0000_0080);
    do_access("lh_0x202", 0, 3'd1, 32'h202, 0, 1, 32'h9ABC_1234, 4'b1100, 32'h0, 32'hFFFF_9ABC);
    do_access("lhu_0x200", 0, 3'd5, 32'h200, 0, 0, 32'h9ABC_F234, 4'b0011, 32'h0, 32'h0000_F234);
    do_access("lb_0x101", 0, 3'd0, 32'h101, 0, 0, 32'h1122_7F44, 4'b0010, 32'h0, 32'h0000_007F);
  endtask

  task automatic test_stores();
    do_access("sh_0x202_gnt3", 1, 3'd1, 32'h202, 32'h1234_ABCD, 3, 32'hFFFF_FFFF, 4'b1100, 32'hABCD_ABCD, 32'h0);
    do_access("sb_0x302", 1, 3'd0, 32'h302, 32'h0000_00A5, 0, 32'h0, 4'b0100, 32'hA5A5_A5A5, 32'h0);
    do_access("sw_0x400", 1, 3'd2, 32'h400, 32'hCAFE_F00D, 2, 32'h0, 4'b1111, 32'hCAFE_F00D, 32'h0);
  endtask

  task automatic check_reject(input string name, input logic we, input logic [2:0] size, input logic [31:0] addr);
    lsu_req_i = 1; lsu_we_i = we; lsu_size_i = size; lsu_addr_i = addr; data_gnt_i = 1;
    @(negedge clk_i);
    n_cmp++;
    if ({lsu_misalign_o, data_req_o, lsu_stall_req_o} !== 3'b100) begin
      n_err++;
      $display("FAIL %s: mis=%b req=%b stall=%b, want mis=1 req=0 stall=0", name, lsu_misalign_o, data_req_o, lsu_stall_req_o);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_misalign();
    check_reject("lw_0x101", 0, 3'd2, 32'h101);
    check_reject("sw_size4", 1, 3'd4, 32'h100);
    check_reject("lh_0x203", 0, 3'd1, 32'h203);
    check_reject("load_size3", 0, 3'd3, 32'h100);
    // FSM must still be IDLE: a legal access issues straight away
    do_access("lw_after_reject", 0, 3'd2, 32'h104, 0, 0, 32'h0BAD_F00D, 4'b1111, 32'h0, 32'h0BAD_F00D);
  endtask

  task automatic test_reset_mid_resp();
    lsu_req_i = 1; lsu_we_i = 0; lsu_size_i = 3'd2; lsu_addr_i = 32'h500; data_gnt_i = 1;
    next_cycle();
    data_gnt_i = 0;
    arstn_i = 0;
    data_rvalid_i = 1; data_rdata_i = 32'h1111_1111;
    #1;
    n_cmp++;
    if ({data_req_o, data_we_o, data_be_o, lsu_stall_req_o, lsu_misalign_o, lsu_data_o} !== 39'd0) begin
      n_err++;
      $display("FAIL reset_in_resp: req=%b we=%b be=%b stall=%b mis=%b data=%h, want all 0",
               data_req_o, data_we_o, data_be_o, lsu_stall_req_o, lsu_misalign_o, lsu_data_o);
    end
    idle_inputs();
    next_cycle();
    arstn_i = 1;
    do_access("lh_0x0_after_reset", 0, 3'd1, 32'h0, 0, 0, 32'h0000_8001, 4'b0011, 32'h0, 32'hFFFF_8001);
  endtask

  task automatic test_back_to_back();
    do_access("b2b_first", 0, 3'd2, 32'h600, 0, 0, 32'h0102_0304, 4'b1111, 32'h0, 32'h0102_0304);
    do_access("b2b_second", 0, 3'd2, 32'h604, 0, 0, 32'hA0B0_C0D0, 4'b1111, 32'h0, 32'hA0B0_C0D0);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misalign();
    test_reset_mid_resp();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/miriscv_lsu.md
MIRISCV_LSU -- requirements
Module: miriscv_lsu

Interface
REQ-001 clk_i  in  1  system clock; all state updates on its rising edge.
REQ-002 arstn_i  in  1  asynchronous active-low reset; one clock only.
REQ-003 lsu_req_i  in  1  core requests a memory access (decoder mem_req).
REQ-004 lsu_we_i  in  1  1 = store, 0 = load (decoder mem_we).
REQ-005 lsu_size_i  in  3  0=B, 1=H, 2=W, 4=BU, 5=HU (decoder mem_size).
REQ-006 lsu_addr_i  in  32  byte address from ALU.
REQ-007 lsu_data_i  in  32  store data (rs2).
REQ-008 lsu_data_o  out  32  extended load result.
REQ-009 lsu_stall_req_o  out  1  core must hold its pipeline while high.
REQ-010 lsu_misalign_o  out  1  access rejected: misaligned address or unsupported size.
REQ-011 data_req_o  out  1  bus request; data_we_o  out  1  bus write enable.
REQ-012 data_be_o  out  4  byte enables; data_addr_o  out  32  word address, {lsu_addr_i[31:2],2'b00}.
REQ-013 data_wdata_o  out  32  lane-replicated store data; data_rdata_i  in  32  read data.
REQ-014 data_gnt_i  in  1  bus accepted request; data_rvalid_i  in  1  response (load data or store ack).

Function
REQ-015 FSM states: IDLE, REQ (request issued, awaiting gnt), RESP (granted, awaiting rvalid).
REQ-016 Access is legal when: size W with addr[1:0]=0; size H/HU with addr[0]=0; size B/BU with any address; stores accept only sizes 0,1,2.
REQ-017 IDLE, lsu_req_i=1, legal: data_req_o=1 in the same cycle; next state RESP if data_gnt_i=1, else REQ.
REQ-018 REQ: data_req_o held at 1 and address/we/be/wdata held stable until data_gnt_i=1; then next state RESP.
REQ-019 RESP: data_req_o=0; on data_rvalid_i=1, next state IDLE.
REQ-020 data_rvalid_i outside RESP and data_gnt_i outside IDLE/REQ request cycles are ignored.
REQ-021 At issue, lsu_addr_i[1:0], lsu_size_i and lsu_we_i are latched; response extraction uses the latched copies.
REQ-022 lsu_stall_req_o = (IDLE and lsu_req_i and legal) or REQ or (RESP and not data_rvalid_i).
REQ-023 Minimum latency: gnt in issue cycle, rvalid next cycle; stall high 1 cycle, low in the rvalid cycle.
REQ-024 Illegal access in IDLE: lsu_misalign_o=1 combinationally, data_req_o=0, lsu_stall_req_o=0, FSM stays IDLE.
REQ-025 Store byte enables: B = 4'b0001<<addr[1:0]; H = 4'b0011<<{addr[1],1'b0}; W = 4'b1111.
REQ-026 Store data: B = {4{data[7:0]}}; H = {2{data[15:0]}}; W = data.
REQ-027 Loads drive data_we_o=0 and the same byte enables as an equal-size store.
REQ-028 lsu_data_o in the RESP/rvalid cycle: B/BU select byte at latched offset, sign-/zero-extend; H/HU select half by latched addr[1], sign-/zero-extend; W passes through.
REQ-029 lsu_data_o is 0 whenever no load response is completing; stores return 0.
REQ-030 Core holds lsu_req_i and operands stable while stall is high; a granted transaction always completes even if lsu_req_i drops.
REQ-031 Back-to-back: a new lsu_req_i in the cycle after rvalid issues immediately from IDLE.

Reset
REQ-032 arstn_i=0 forces IDLE immediately, mid-transaction included, and clears latched offset/size/we.
REQ-033 During reset: data_req_o=0, data_we_o=0, data_be_o=0, lsu_stall_req_o=0, lsu_misalign_o=0, lsu_data_o=0.
REQ-034 First request is accepted in the first clock edge after arstn_i rises.

Verification
REQ-035 LW addr 0x100, gnt same cycle, rvalid next with rdata 0xDEADBEEF -> data_addr_o 0x100, be 1111, stall 1 then 0, lsu_data_o 0xDEADBEEF.
REQ-036 LB addr 0x103, rdata 0x80FF_FF7F -> be 1000, lsu_data_o 0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-037 SH addr 0x202, data 0x1234_ABCD, gnt delayed 3 cycles -> data_req_o high 4 cycles with stable outputs, be 1100, wdata 0xABCD_ABCD, stall until rvalid.
REQ-038 LW addr 0x101 -> lsu_misalign_o 1, data_req_o 0, stall 0; SW size 4 -> same.
REQ-039 arstn_i low while in RESP -> all outputs 0 at once; after release a LH at 0x0 completes normally.
REQ-040 Two LW back-to-back with gnt and rvalid immediate -> second data_req_o asserts the cycle after first rvalid, no bubble.
